// File: rtl/maj_check_sequencer.sv
// Bounded stimulus/check controller for a majority netlist: drives x, compares y_dut after LAT edges.
// One vector per LAT+1 cycles; no backpressure, start is ignored while a run is in progress.
module maj_check_sequencer #(
  parameter int          N      = 43,
  parameter int          THRESH = 22,
  parameter int          LAT    = 0,
  parameter int          CNT_W  = 32,
  parameter logic [N-1:0] SEED  = N'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] num_vec,
  output logic [N-1:0]     x,
  input  logic             y_dut,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [N-1:0]     first_err_vec
);

  localparam int PW = $clog2(N + 1);
  localparam logic [3:0] LAT_C = 4'(LAT);

  function automatic logic [63:0] tb(input int t);
    tb = 64'd1 << (t - 1);
  endfunction

  // Maximal-length Fibonacci taps, indexed by register length.
  function automatic logic [N-1:0] tap_mask();
    logic [63:0] m;
    case (N)
      3:       m = tb(3)  | tb(2);
      5:       m = tb(5)  | tb(3);
      7:       m = tb(7)  | tb(6);
      9:       m = tb(9)  | tb(5);
      11:      m = tb(11) | tb(9);
      13:      m = tb(13) | tb(4)  | tb(3)  | tb(1);
      15:      m = tb(15) | tb(14);
      17:      m = tb(17) | tb(14);
      19:      m = tb(19) | tb(6)  | tb(2)  | tb(1);
      21:      m = tb(21) | tb(19);
      23:      m = tb(23) | tb(18);
      25:      m = tb(25) | tb(22);
      27:      m = tb(27) | tb(5)  | tb(2)  | tb(1);
      29:      m = tb(29) | tb(27);
      31:      m = tb(31) | tb(28);
      33:      m = tb(33) | tb(20);
      35:      m = tb(35) | tb(33);
      37:      m = tb(37) | tb(5)  | tb(4)  | tb(3) | tb(2) | tb(1);
      39:      m = tb(39) | tb(35);
      41:      m = tb(41) | tb(38);
      43:      m = tb(43) | tb(42) | tb(38) | tb(37);
      45:      m = tb(45) | tb(44) | tb(42) | tb(41);
      47:      m = tb(47) | tb(42);
      49:      m = tb(49) | tb(40);
      51:      m = tb(51) | tb(50) | tb(48) | tb(45);
      53:      m = tb(53) | tb(52) | tb(51) | tb(47);
      55:      m = tb(55) | tb(31);
      57:      m = tb(57) | tb(50);
      59:      m = tb(59) | tb(58) | tb(38) | tb(37);
      61:      m = tb(61) | tb(60) | tb(46) | tb(45);
      63:      m = tb(63) | tb(62);
      default: m = tb(N)  | tb(N - 1);
    endcase
    tap_mask = m[N-1:0];
  endfunction

  localparam logic [N-1:0] TAPS = tap_mask();

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     x_q;
  logic             mode_q;
  logic [CNT_W-1:0] num_vec_q;
  logic [CNT_W-1:0] vec_cnt_q;
  logic [CNT_W-1:0] err_count_q;
  logic [3:0]       hold_q;
  logic             fev_q;
  logic [N-1:0]     fevec_q;

  logic [PW-1:0]    pop;
  logic             ref_bit;
  logic             fb;
  logic [N-1:0]     x_next;
  logic             accept, cmp, last, mismatch;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + PW'(x_q[i]);
  end

  assign ref_bit  = ({{(32 - PW){1'b0}}, pop} >= THRESH);
  assign fb       = ^(x_q & TAPS);
  assign x_next   = mode_q ? {x_q[N-2:0], fb} : x_q + N'(1);
  assign mismatch = cmp & (y_dut ^ ref_bit);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cmp     = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (num_vec != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (hold_q == LAT_C) begin
          cmp = 1'b1;
          if (vec_cnt_q == num_vec_q - CNT_W'(1)) begin
            last    = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q         <= '0;
      mode_q      <= 1'b0;
      num_vec_q   <= '0;
      vec_cnt_q   <= '0;
      err_count_q <= '0;
      hold_q      <= '0;
      fev_q       <= 1'b0;
      fevec_q     <= '0;
    end else if (accept) begin
      mode_q      <= mode;
      num_vec_q   <= num_vec;
      vec_cnt_q   <= '0;
      err_count_q <= '0;
      hold_q      <= '0;
      fev_q       <= 1'b0;
      fevec_q     <= '0;
      x_q         <= (num_vec == '0) ? '0 : (mode ? SEED : '0);
    end else if (state_q == RUN) begin
      if (cmp) begin
        if (mismatch) begin
          if (err_count_q != '1) err_count_q <= err_count_q + CNT_W'(1);
          if (!fev_q) begin
            fev_q   <= 1'b1;
            fevec_q <= x_q;
          end
        end
        vec_cnt_q <= vec_cnt_q + CNT_W'(1);
        hold_q    <= '0;
        x_q       <= last ? '0 : x_next;
      end else begin
        hold_q <= hold_q + 4'd1;
      end
    end
  end

  assign x               = x_q;
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign err_count       = err_count_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fevec_q;

endmodule

// File: tb/tb_maj_check_sequencer.sv
// Directed bench: three sequencer configurations against behavioural majority DUTs.
module tb_maj_check_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // N=5, LAT=0, combinational majority (optionally faulty threshold 2)
  logic        s5, m5, y5, busy5, done5, fv5, fault5;
  logic [31:0] nv5, ec5;
  logic [4:0]  x5, fe5;
  assign y5 = fault5 ? ($countones(x5) >= 2) : ($countones(x5) >= 3);

  maj_check_sequencer #(.N(5), .THRESH(3), .LAT(0), .CNT_W(32), .SEED(5'd1)) dut5 (
    .clk(clk), .rst(rst), .start(s5), .mode(m5), .num_vec(nv5), .x(x5), .y_dut(y5),
    .busy(busy5), .done(done5), .err_count(ec5), .first_err_valid(fv5), .first_err_vec(fe5)
  );

  // N=43, LAT=2, two-register ideal majority
  logic        s43, m43, y43, p43, busy43, done43, fv43;
  logic [31:0] nv43, ec43;
  logic [42:0] x43, fe43;
  always_ff @(posedge clk) begin
    p43 <= ($countones(x43) >= 22);
    y43 <= p43;
  end

  maj_check_sequencer #(.N(43), .THRESH(22), .LAT(2), .CNT_W(32), .SEED(43'd1)) dut43 (
    .clk(clk), .rst(rst), .start(s43), .mode(m43), .num_vec(nv43), .x(x43), .y_dut(y43),
    .busy(busy43), .done(done43), .err_count(ec43), .first_err_valid(fv43), .first_err_vec(fe43)
  );

  // N=3, LAT=0, ideal majority
  logic        s3, m3, y3, busy3, done3, fv3;
  logic [31:0] nv3, ec3;
  logic [2:0]  x3, fe3;
  assign y3 = ($countones(x3) >= 2);

  maj_check_sequencer #(.N(3), .THRESH(2), .LAT(0), .CNT_W(32), .SEED(3'd1)) dut3 (
    .clk(clk), .rst(rst), .start(s3), .mode(m3), .num_vec(nv3), .x(x3), .y_dut(y3),
    .busy(busy3), .done(done3), .err_count(ec3), .first_err_valid(fv3), .first_err_vec(fe3)
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (x5 !== 5'd0)  begin errors++; $display("FAIL reset_x got=%0d exp=0", x5); end
    checks++; if (busy5 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy5); end
    checks++; if (done5 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done5); end
    checks++; if (ec5 !== 32'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", ec5); end
    checks++; if (fv5 !== 1'b0) begin errors++; $display("FAIL reset_fev got=%b exp=0", fv5); end
    checks++; if (fe5 !== 5'd0) begin errors++; $display("FAIL reset_fevec got=%0d exp=0", fe5); end
  endtask

  // Starts a 32-vector mode-0 run on dut5 and returns the number of busy cycles.
  task automatic run5(output int cyc);
    @(negedge clk);
    s5 = 1'b1; m5 = 1'b0; nv5 = 32'd32;
    @(negedge clk);
    s5 = 1'b0;
    cyc = 0;
    while (busy5 === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_exhaustive_ideal();
    int cyc;
    fault5 = 1'b0;
    run5(cyc);
    checks++; if (cyc != 32) begin errors++; $display("FAIL ideal_len got=%0d exp=32", cyc); end
    checks++; if (done5 !== 1'b1) begin errors++; $display("FAIL ideal_done got=%b exp=1", done5); end
    checks++; if (ec5 !== 32'd0) begin errors++; $display("FAIL ideal_err got=%0d exp=0", ec5); end
    checks++; if (fv5 !== 1'b0) begin errors++; $display("FAIL ideal_fev got=%b exp=0", fv5); end
    checks++; if (x5 !== 5'd0) begin errors++; $display("FAIL ideal_x_done got=%0d exp=0", x5); end
  endtask

  task automatic test_faulty_dut();
    int cyc;
    fault5 = 1'b1;
    run5(cyc);
    fault5 = 1'b0;
    checks++; if (cyc != 32) begin errors++; $display("FAIL faulty_len got=%0d exp=32", cyc); end
    checks++; if (ec5 !== 32'd10) begin errors++; $display("FAIL faulty_err got=%0d exp=10", ec5); end
    checks++; if (fv5 !== 1'b1) begin errors++; $display("FAIL faulty_fev got=%b exp=1", fv5); end
    checks++; if (fe5 !== 5'b00011) begin errors++; $display("FAIL faulty_fevec got=%b exp=00011", fe5); end
  endtask

  task automatic test_lfsr();
    int cyc;
    logic [42:0] exp_x [3];
    exp_x[0] = 43'd1; exp_x[1] = 43'd2; exp_x[2] = 43'd4;
    @(negedge clk);
    s43 = 1'b1; m43 = 1'b1; nv43 = 32'd1000;
    @(negedge clk);
    s43 = 1'b0;
    cyc = 0;
    while (busy43 === 1'b1 && cyc < 4000) begin
      if (cyc < 9) begin
        checks++;
        if (x43 !== exp_x[cyc / 3]) begin
          errors++; $display("FAIL lfsr_x[%0d] got=%0h exp=%0h", cyc, x43, exp_x[cyc / 3]);
        end
      end
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc != 3000) begin errors++; $display("FAIL lfsr_len got=%0d exp=3000", cyc); end
    checks++; if (ec43 !== 32'd0) begin errors++; $display("FAIL lfsr_err got=%0d exp=0", ec43); end
    checks++; if (done43 !== 1'b1) begin errors++; $display("FAIL lfsr_done got=%b exp=1", done43); end
  endtask

  task automatic test_zero_vec();
    int saw_busy = 0;
    @(negedge clk);
    s5 = 1'b1; m5 = 1'b0; nv5 = 32'd0;
    @(negedge clk);
    s5 = 1'b0;
    checks++; if (done5 !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done5); end
    checks++; if (ec5 !== 32'd0) begin errors++; $display("FAIL zero_err got=%0d exp=0", ec5); end
    for (int i = 0; i < 4; i++) begin
      if (busy5 === 1'b1) saw_busy++;
      @(negedge clk);
    end
    checks++; if (saw_busy != 0) begin errors++; $display("FAIL zero_busy got=%0d exp=0", saw_busy); end
  endtask

  task automatic test_rst_midrun();
    int cyc;
    int guard = 0;
    @(negedge clk);
    s5 = 1'b1; m5 = 1'b0; nv5 = 32'd32;
    @(negedge clk);
    s5 = 1'b0;
    while (x5 !== 5'd10 && guard < 100) begin guard++; @(negedge clk); end
    checks++; if (guard >= 100) begin errors++; $display("FAIL midrun_reach got=%0d exp<100", guard); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (x5 !== 5'd0) begin errors++; $display("FAIL midrun_x got=%0d exp=0", x5); end
    checks++; if (busy5 !== 1'b0 || done5 !== 1'b0) begin
      errors++; $display("FAIL midrun_state got=busy%b/done%b exp=0/0", busy5, done5); end
    checks++; if (ec5 !== 32'd0 || fv5 !== 1'b0 || fe5 !== 5'd0) begin
      errors++; $display("FAIL midrun_res got=%0d/%b/%0d exp=0/0/0", ec5, fv5, fe5); end
    // rst and start together: rst wins
    s5 = 1'b1; nv5 = 32'd5; rst = 1'b1;
    @(negedge clk);
    s5 = 1'b0; rst = 1'b0;
    checks++; if (busy5 !== 1'b0 || done5 !== 1'b0) begin
      errors++; $display("FAIL rst_start got=busy%b/done%b exp=0/0", busy5, done5); end
    s5 = 1'b1; nv5 = 32'd32;
    @(negedge clk);
    s5 = 1'b0;
    checks++; if (x5 !== 5'd0 || busy5 !== 1'b1) begin
      errors++; $display("FAIL restart got=x%0d/busy%b exp=0/1", x5, busy5); end
    cyc = 0;
    while (busy5 === 1'b1 && cyc < 200) begin cyc++; @(negedge clk); end
    checks++; if (cyc != 32 || ec5 !== 32'd0) begin
      errors++; $display("FAIL restart_run got=len%0d/err%0d exp=32/0", cyc, ec5); end
  endtask

  task automatic test_wrap_start_ignore();
    int cyc;
    logic [2:0] x_at8;
    x_at8 = 3'd7;
    @(negedge clk);
    s3 = 1'b1; m3 = 1'b0; nv3 = 32'd10;
    @(negedge clk);
    s3 = 1'b0;
    cyc = 0;
    while (busy3 === 1'b1 && cyc < 100) begin
      if (cyc == 3) begin s3 = 1'b1; nv3 = 32'd3; end
      if (cyc == 4) s3 = 1'b0;
      if (cyc == 8) x_at8 = x3;
      cyc++;
      @(negedge clk);
    end
    checks++; if (cyc != 10) begin errors++; $display("FAIL wrap_len got=%0d exp=10", cyc); end
    checks++; if (x_at8 !== 3'd0) begin errors++; $display("FAIL wrap_x8 got=%0d exp=0", x_at8); end
    checks++; if (ec3 !== 32'd0 || done3 !== 1'b1) begin
      errors++; $display("FAIL wrap_res got=err%0d/done%b exp=0/1", ec3, done3); end
  endtask

  initial begin
    rst = 1'b1; fault5 = 1'b0;
    s5 = 1'b0; m5 = 1'b0; nv5 = '0;
    s43 = 1'b0; m43 = 1'b0; nv43 = '0;
    s3 = 1'b0; m3 = 1'b0; nv3 = '0;
    test_reset();
    test_exhaustive_ideal();
    test_faulty_dut();
    test_lfsr();
    test_zero_vec();
    test_rst_midrun();
    test_wrap_start_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
